// File: rtl/vga_scan_timing_gen_if.sv
// Scan-timing bundle carried from the raster generator to the pixel-mux and
// VGA output logic. The generator drives it through the master modport.
interface vga_scan_timing_gen_if;
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       tile_active;
    logic       frame_start;

    modport master (
        output pclk_en, h_cnt, v_cnt, hsync, vsync, valid, tile_active, frame_start
    );

    modport slave (
        input  pclk_en, h_cnt, v_cnt, hsync, vsync, valid, tile_active, frame_start
    );
endinterface

// File: rtl/vga_scan_timing_gen.sv
// 640x480@60 raster scan generator: pixel-rate enable, scan counters, active-low
// syncs, visible-area flag and a square tile window flag. All decodes come from
// the registered counters only, so they stay aligned with h_cnt/v_cnt.
module vga_scan_timing_gen #(
    parameter int DIV       = 4,
    parameter int H_VIS     = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VIS     = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int TILE_X0   = 224,
    parameter int TILE_Y0   = 208,
    parameter int TILE_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_scan_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Decode thresholds kept at 11 bits so parameter sums cannot wrap.
    localparam logic [10:0] H_VIS_E  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_E  = 11'(V_VIS);
    localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] TILE_XB  = 11'(TILE_X0);
    localparam logic [10:0] TILE_XE  = 11'(TILE_X0 + TILE_SIZE);
    localparam logic [10:0] TILE_YB  = 11'(TILE_Y0);
    localparam logic [10:0] TILE_YE  = 11'(TILE_Y0 + TILE_SIZE);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pclk_en_q, pclk_en_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             h_wrap, v_wrap;
    logic [10:0]      h_ext, v_ext;
    logic             valid_w, hsync_w, vsync_w, tile_w, frame_start_w;

    // Next-state: clock divider, pixel enable, and the scan counters.
    // pclk_en is registered from the next divider value, so it is high
    // exactly while div_cnt_q sits at DIV-1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pclk_en_d = (div_cnt_d == DIV_LAST);
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pclk_en_q) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // State registers; reset returns the scan to (0,0) with the divider at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            pclk_en_q <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pclk_en_q <= pclk_en_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    // Zero-latency decodes from the registered counts.
    always_comb begin
        h_ext         = {1'b0, h_cnt_q};
        v_ext         = {1'b0, v_cnt_q};
        valid_w       = (h_ext < H_VIS_E) && (v_ext < V_VIS_E);
        hsync_w       = !((h_ext >= HS_BEG) && (h_ext < HS_END));
        vsync_w       = !((v_ext >= VS_BEG) && (v_ext < VS_END));
        tile_w        = valid_w &&
                        (h_ext >= TILE_XB) && (h_ext < TILE_XE) &&
                        (v_ext >= TILE_YB) && (v_ext < TILE_YE);
        frame_start_w = pclk_en_q && h_wrap && v_wrap;
    end

    assign vga.pclk_en     = pclk_en_q;
    assign vga.h_cnt       = h_cnt_q;
    assign vga.v_cnt       = v_cnt_q;
    assign vga.hsync       = hsync_w;
    assign vga.vsync       = vsync_w;
    assign vga.valid       = valid_w;
    assign vga.tile_active = tile_w;
    assign vga.frame_start = frame_start_w;
endmodule

// File: tb/tb_vga_scan_timing_gen.sv
// Bench for vga_scan_timing_gen. Three instances share one clock:
//   A: default 640x480 timing, DIV=4 (reset, pixel pulses, line wrap, hsync).
//   B: DIV=1, 8x6 totals (constant pixel enable, 48-clk frame, sync spots).
//   C: DIV=3, 18x14 totals, tile at x 6..9 / y 5..8 (tile edges, frame wrap,
//      vsync, mid-frame reset).
// Stimulus queues hand-computed expected outputs tagged with a cycle; a
// negedge monitor pops and compares them against the DUT outputs.
module tb_vga_scan_timing_gen;
    typedef struct packed {
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vld;
        logic       tile;
        logic       fs;
    } obs_t;

    typedef struct {
        int    cyc;
        string nm;
        obs_t  o;
    } exp_t;

    typedef exp_t exp_q_t[$];

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   cyc = 0;
    int   rel = 1 << 30;
    int   rel2;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_q_t expq [3];

    int a_hs_lo = 0, a_vld_lo = 0, b_pe = 0, c_vs_lo = 0, c_tile = 0;
    int b_fs[$];
    int c_fs[$];

    vga_scan_timing_gen_if if_a ();
    vga_scan_timing_gen_if if_b ();
    vga_scan_timing_gen_if if_c ();

    vga_scan_timing_gen u_a (.clk(clk), .rst(rst_a), .vga(if_a));

    vga_scan_timing_gen #(
        .DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (.clk(clk), .rst(rst_b), .vga(if_b));

    vga_scan_timing_gen #(
        .DIV(3), .H_VIS(12), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_VIS(10), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .TILE_X0(6), .TILE_Y0(5), .TILE_SIZE(4)
    ) u_c (.clk(clk), .rst(rst_c), .vga(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(obs_t o);
        return $sformatf("pe=%0b h=%0d v=%0d hs=%0b vs=%0b vld=%0b tile=%0b fs=%0b",
                         o.pe, o.h, o.v, o.hs, o.vs, o.vld, o.tile, o.fs);
    endfunction

    function automatic void push(int d, int c, string nm, logic pe, int h, int v,
                                 logic hs, logic vs, logic vld, logic tile, logic fs);
        exp_t e;
        e.cyc    = c;
        e.nm     = nm;
        e.o.pe   = pe;
        e.o.h    = 10'(h);
        e.o.v    = 10'(v);
        e.o.hs   = hs;
        e.o.vs   = vs;
        e.o.vld  = vld;
        e.o.tile = tile;
        e.o.fs   = fs;
        expq[d].push_back(e);
    endfunction

    task automatic check_int(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: compare each queued expectation on its cycle.
    always @(negedge clk) begin
        obs_t ob [3];
        exp_t e;
        ob[0] = {if_a.pclk_en, if_a.h_cnt, if_a.v_cnt, if_a.hsync, if_a.vsync,
                 if_a.valid, if_a.tile_active, if_a.frame_start};
        ob[1] = {if_b.pclk_en, if_b.h_cnt, if_b.v_cnt, if_b.hsync, if_b.vsync,
                 if_b.valid, if_b.tile_active, if_b.frame_start};
        ob[2] = {if_c.pclk_en, if_c.h_cnt, if_c.v_cnt, if_c.hsync, if_c.vsync,
                 if_c.valid, if_c.tile_active, if_c.frame_start};
        for (int d = 0; d < 3; d++) begin
            while (expq[d].size() > 0 && expq[d][0].cyc < cyc) begin
                e = expq[d].pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: never sampled (cycle %0d passed)", e.nm, e.cyc);
            end
            if (expq[d].size() > 0 && expq[d][0].cyc == cyc) begin
                e = expq[d].pop_front();
                n_cmp++;
                if (ob[d] !== e.o) begin
                    n_bad++;
                    $display("FAIL %s: got %s, expected %s", e.nm, fmt(ob[d]), fmt(e.o));
                end
            end
        end
    end

    // Rate measurements over fixed windows after reset release.
    always @(negedge clk) begin
        if (cyc >= rel && cyc <= rel + 3199) begin
            if (if_a.hsync === 1'b0) a_hs_lo++;
            if (if_a.valid === 1'b0) a_vld_lo++;
        end
        if (cyc >= rel + 1 && cyc <= rel + 200) begin
            if (if_b.pclk_en === 1'b1) b_pe++;
            if (if_b.frame_start === 1'b1) b_fs.push_back(cyc);
        end
        if (cyc >= rel && cyc <= rel + 755) begin
            if (if_c.vsync === 1'b0) c_vs_lo++;
            if (if_c.tile_active === 1'b1 && if_c.pclk_en === 1'b1) c_tile++;
        end
        if (cyc >= rel && cyc <= rel + 1915 && if_c.frame_start === 1'b1)
            c_fs.push_back(cyc);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rel   = cyc;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // A: default timing, DIV=4; pixel n/4 after release, pe when n%4==3.
        push(0, rel + 0,    "a_reset",      0,   0, 0, 1, 1, 1, 0, 0);
        push(0, rel + 3,    "a_pe_first",   1,   0, 0, 1, 1, 1, 0, 0);
        push(0, rel + 4,    "a_h1",         0,   1, 0, 1, 1, 1, 0, 0);
        push(0, rel + 7,    "a_pe_second",  1,   1, 0, 1, 1, 1, 0, 0);
        push(0, rel + 8,    "a_h2",         0,   2, 0, 1, 1, 1, 0, 0);
        push(0, rel + 11,   "a_pe_third",   1,   2, 0, 1, 1, 1, 0, 0);
        push(0, rel + 12,   "a_h3",         0,   3, 0, 1, 1, 1, 0, 0);
        push(0, rel + 899,  "a_tile_v0",    1, 224, 0, 1, 1, 1, 0, 0);
        push(0, rel + 2559, "a_h639",       1, 639, 0, 1, 1, 1, 0, 0);
        push(0, rel + 2560, "a_h640",       0, 640, 0, 1, 1, 0, 0, 0);
        push(0, rel + 2623, "a_h655",       1, 655, 0, 1, 1, 0, 0, 0);
        push(0, rel + 2624, "a_hs_start",   0, 656, 0, 0, 1, 0, 0, 0);
        push(0, rel + 3007, "a_hs_last",    1, 751, 0, 0, 1, 0, 0, 0);
        push(0, rel + 3008, "a_hs_end",     0, 752, 0, 1, 1, 0, 0, 0);
        push(0, rel + 3199, "a_h799",       1, 799, 0, 1, 1, 0, 0, 0);
        push(0, rel + 3200, "a_line_wrap",  0,   0, 1, 1, 1, 1, 0, 0);

        // B: DIV=1, 8x6; pixel n-1 after release for n>=1.
        push(1, rel + 0,  "b_reset",      0, 0, 0, 1, 1, 1, 0, 0);
        push(1, rel + 1,  "b_pe_on",      1, 0, 0, 1, 1, 1, 0, 0);
        push(1, rel + 6,  "b_hsync",      1, 5, 0, 0, 1, 0, 0, 0);
        push(1, rel + 7,  "b_hsync_end",  1, 6, 0, 1, 1, 0, 0, 0);
        push(1, rel + 34, "b_vsync",      1, 1, 4, 1, 0, 0, 0, 0);
        push(1, rel + 48, "b_frame_wrap", 1, 7, 5, 1, 1, 0, 0, 1);
        push(1, rel + 49, "b_origin",     1, 0, 0, 1, 1, 1, 0, 0);

        // C: DIV=3, 18x14; pixel n/3 after release, pe when n%3==2.
        push(2, rel + 208,  "c_hsync",       0, 15,  3, 0, 1, 0, 0, 0);
        push(2, rel + 235,  "c_tile_above",  0,  6,  4, 1, 1, 1, 0, 0);
        push(2, rel + 286,  "c_tile_left",   0,  5,  5, 1, 1, 1, 0, 0);
        push(2, rel + 289,  "c_tile_corner", 0,  6,  5, 1, 1, 1, 1, 0);
        push(2, rel + 301,  "c_tile_right",  0, 10,  5, 1, 1, 1, 0, 0);
        push(2, rel + 460,  "c_tile_last",   0,  9,  8, 1, 1, 1, 1, 0);
        push(2, rel + 505,  "c_tile_below",  0,  6,  9, 1, 1, 1, 0, 0);
        push(2, rel + 595,  "c_vsync",       0,  0, 11, 1, 0, 0, 0, 0);
        push(2, rel + 755,  "c_frame_wrap",  1, 17, 13, 1, 1, 0, 0, 1);
        push(2, rel + 756,  "c_origin",      0,  0,  0, 1, 1, 1, 0, 0);
        push(2, rel + 1915, "c_before_rst",  0,  8,  7, 1, 1, 1, 1, 0);

        // Mid-frame reset on C for one clock while it sits at (8,7).
        repeat (1915) @(posedge clk);
        #1 rst_c = 1'b1;
        @(posedge clk);
        #1;
        rst_c = 1'b0;
        rel2  = cyc;
        push(2, rel2 + 0, "c_rst_state",  0, 0, 0, 1, 1, 1, 0, 0);
        push(2, rel2 + 1, "c_rst_hold",   0, 0, 0, 1, 1, 1, 0, 0);
        push(2, rel2 + 2, "c_rst_pe",     1, 0, 0, 1, 1, 1, 0, 0);
        push(2, rel2 + 3, "c_rst_resume", 0, 1, 0, 1, 1, 1, 0, 0);

        repeat (1300) @(posedge clk);
        #1;

        check_int("a_hsync_low_clks", a_hs_lo, 384);
        check_int("a_valid_low_clks", a_vld_lo, 640);
        check_int("b_pclk_en_clks", b_pe, 200);
        check_int("b_frame_starts", b_fs.size(), 4);
        if (b_fs.size() >= 2) check_int("b_frame_period", b_fs[1] - b_fs[0], 48);
        check_int("c_vsync_low_clks", c_vs_lo, 108);
        check_int("c_tile_pixels", c_tile, 16);
        check_int("c_frame_starts", c_fs.size(), 2);
        if (c_fs.size() >= 2) check_int("c_frame_period", c_fs[1] - c_fs[0], 756);
        for (int d = 0; d < 3; d++)
            check_int($sformatf("pending_vectors_%0d", d), expq[d].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_scan_timing_gen.md
Name: vga_scan_timing_gen

Overview:
- Generates the 640x480@60 Hz raster scan: pixel-rate enable, h_cnt/v_cnt, hsync/vsync, and a visible-area flag.
- Produces the h_cnt/v_cnt scan coordinates consumed by the pixel-address generators and the sprite/digit ROM read path.
- Also flags a programmable square tile window so downstream muxes can select tile pixels over background.
- Sits between the board clock and the VGA output/pixel-mux logic.

Parameters:
- DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 1
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- TILE_X0, 224, tile window left column
- TILE_Y0, 208, tile window top line
- TILE_SIZE, 64, tile window edge length in pixels

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pclk_en  out  1  one-clk pixel enable pulse, every DIV clks
- h_cnt  out  10  current column, 0..H_TOTAL-1
- v_cnt  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- valid  out  1  high in the visible area
- tile_active  out  1  high inside the tile window (also visible)
- frame_start  out  1  one-clk pulse on the last-pixel-to-(0,0) wrap

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Derived constants: H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_VIS+V_FP+V_SYNC+V_BP (525).
- Divider: div_cnt counts 0..DIV-1 and wraps.
  - pclk_en is registered and is 1 exactly when div_cnt==DIV-1.
  - With DIV=1, pclk_en is 1 every clk after reset deasserts.
- Counters advance only on clks where pclk_en=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - h_cnt and v_cnt hold otherwise.
- Decodes are combinational from the registered h_cnt/v_cnt (zero latency, always aligned with the counts):
  - valid = (h_cnt<H_VIS) && (v_cnt<V_VIS)
  - hsync = 0 iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751)
  - vsync = 0 iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491)
  - tile_active = valid && TILE_X0<=h_cnt<TILE_X0+TILE_SIZE && TILE_Y0<=v_cnt<TILE_Y0+TILE_SIZE
  - Comparisons use unsigned values of at least 11 bits, so parameter sums never overflow.
- frame_start = pclk_en && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1. It is high for exactly one clk per frame, on the clk before the counters show (0,0).
- Reset values: div_cnt=0, pclk_en=0, h_cnt=0, v_cnt=0.
  - Resulting outputs: hsync=1, vsync=1, valid=1, tile_active=0 (default tile), frame_start=0.
- Reset mid-frame: on the next clk edge, all state returns to the reset values regardless of position.
  - After rst falls, the first pclk_en occurs DIV clks later; h_cnt becomes 1 on that edge.
- Rates with defaults: line = 3200 clk, frame = 1,680,000 clk.
  - hsync low 96 px (384 clk) per line; vsync low 2 lines (6400 clk) per frame.
- No combinational path from any input to any output except through the registers.

Test Plan:
- Reset, DIV=4: hold rst 3 clks, release.
  - Expect pclk_en pulses at clks 4, 8, 12 after release.
  - Expect h_cnt 0 -> 1 -> 2 on those pulses, v_cnt=0, valid=1, hsync=vsync=1.
- Line wrap: run to h_cnt=799 with v_cnt=0.
  - Next pclk_en: h_cnt=0, v_cnt=1.
  - hsync low exactly for h_cnt 656..751 (384 clks); valid low for h_cnt 640..799.
- Frame wrap: run to (799,524).
  - frame_start=1 for one clk on the wrap, then counts show (0,0).
  - frame_start period measured = 1,680,000 clks; vsync low only for v_cnt 490..491.
- Tile window: sample across a frame.
  - tile_active=1 exactly for h 224..287 and v 208..271 (4096 pixels per frame).
  - tile_active=0 at (223,208), (288,208), (224,207) and (224,272).
- Reset mid-frame: assert rst for 1 clk at (400,300).
  - Next clk: h_cnt=0, v_cnt=0, pclk_en=0, frame_start=0.
  - Counting resumes 4 clks after release.
- DIV=1, H_TOTAL/V_TOTAL shrunk via parameters (e.g. 8/6 totals with 1-px porches/syncs).
  - pclk_en constant 1 after reset; frame_start period = 48 clks.
  - sync pulses land at the computed positions.
